// File: rtl/dma_copy_engine.sv
// Word-copy DMA engine: register slave port plus a request/grant master port.
// Optional completion interrupt enabled by defining DMA_COPY_IRQ_EN.
module dma_copy_engine #(
    parameter int LEN_W = 12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        s_we,
    input  logic [1:0]  s_addr,
    input  logic [31:0] s_wd,
    output logic [31:0] s_rd,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wd,
    input  logic [31:0] m_rd,
    input  logic        m_gnt
`ifdef DMA_COPY_IRQ_EN
    ,
    output logic        irq
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    state_t           state;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] len;
    logic [31:0]      buffer;
    logic             done;
    logic             busy;

    logic wr_src, wr_dst, wr_len, wr_ctrl, start, done_clr;

    assign wr_src   = s_we && (s_addr == 2'd0);
    assign wr_dst   = s_we && (s_addr == 2'd1);
    assign wr_len   = s_we && (s_addr == 2'd2);
    assign wr_ctrl  = s_we && (s_addr == 2'd3);
    assign start    = wr_ctrl && s_wd[0];
    assign done_clr = wr_ctrl && s_wd[1];

    assign busy = (state != IDLE);
    // The buffer register drives the write-data bus directly, so it holds through stalls.
    assign m_wd = buffer;

    // NOTE: every sequential assignment is non-blocking so all state updates see pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            src    <= '0;
            dst    <= '0;
            len    <= '0;
            buffer <= '0;
            done   <= 1'b0;
            m_req  <= 1'b0;
            m_we   <= 1'b0;
            m_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_src) src <= {s_wd[31:2], 2'b00};
                    if (wr_dst) dst <= {s_wd[31:2], 2'b00};
                    if (wr_len) len <= s_wd[LEN_W-1:0];
                    if (start) begin
                        if (len != '0) begin
                            done   <= 1'b0;
                            state  <= RD;
                            m_req  <= 1'b1;
                            m_we   <= 1'b0;
                            m_addr <= src;
                        end else begin
                            done <= 1'b1;
                        end
                    end else if (done_clr) begin
                        done <= 1'b0;
                    end
                end
                RD: begin
                    if (m_gnt) begin
                        buffer <= m_rd;
                        src    <= src + 32'd4;
                        state  <= WR;
                        m_we   <= 1'b1;
                        m_addr <= dst;
                    end
                end
                WR: begin
                    if (m_gnt) begin
                        dst <= dst + 32'd4;
                        len <= len - LEN_W'(1);
                        m_we <= 1'b0;
                        if (len == LEN_W'(1)) begin
                            done  <= 1'b1;
                            state <= IDLE;
                            m_req <= 1'b0;
                        end else begin
                            state  <= RD;
                            m_addr <= src;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    m_req <= 1'b0;
                    m_we  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMA_COPY_IRQ_EN
    logic ie;

    // irq lags done/ie by one cycle, so it drops the cycle after the clearing write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ie  <= 1'b0;
            irq <= 1'b0;
        end else begin
            if (wr_ctrl) ie <= s_wd[2];
            irq <= done && ie;
        end
    end

    always_comb begin
        s_rd = '0;
        case (s_addr)
            2'd0:    s_rd = src;
            2'd1:    s_rd = dst;
            2'd2:    s_rd = 32'(len);
            default: s_rd = {29'b0, ie, done, busy};
        endcase
    end
`else
    always_comb begin
        s_rd = '0;
        case (s_addr)
            2'd0:    s_rd = src;
            2'd1:    s_rd = dst;
            2'd2:    s_rd = 32'(len);
            default: s_rd = {30'b0, done, busy};
        endcase
    end
`endif

endmodule

// File: tb/tb_dma_copy_engine.sv
// Scoreboard bench for dma_copy_engine: expected bus accesses and register reads
// are queued by the stimulus and consumed by a negedge monitor.
module tb_dma_copy_engine;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        s_we = 1'b0;
    logic [1:0]  s_addr = 2'd0;
    logic [31:0] s_wd = '0;
    logic [31:0] s_rd;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wd;
    logic [31:0] m_rd = '0;
    logic        m_gnt = 1'b1;
    logic        rd_vld = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        string       name;
    } bus_t;

    typedef struct {
        logic [31:0] val;
        string       name;
    } rd_t;

    bus_t bus_q[$];
    rd_t  rd_q[$];
    logic [31:0] mem [0:255];

    dma_copy_engine #(.LEN_W(12)) dut (
        .clock  (clock),
        .reset  (reset),
        .s_we   (s_we),
        .s_addr (s_addr),
        .s_wd   (s_wd),
        .s_rd   (s_rd),
        .m_req  (m_req),
        .m_we   (m_we),
        .m_addr (m_addr),
        .m_wd   (m_wd),
        .m_rd   (m_rd),
        .m_gnt  (m_gnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory model and monitor: accesses granted for the coming edge are visible at negedge.
    initial begin
        bus_t b;
        rd_t  r;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 32'hA;
        mem[8'h11] = 32'hB;
        mem[8'h12] = 32'hC;
        mem[8'hFF] = 32'h11;
        mem[8'h00] = 32'h22;
        forever begin
            @(negedge clock);
            if (!reset && m_req && m_gnt) begin
                if (bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bus: we=%0b addr=0x%08h required no access", m_we, m_addr);
                end else begin
                    b = bus_q.pop_front();
                    check({b.name, "_we"}, {31'b0, m_we}, {31'b0, b.we});
                    check({b.name, "_addr"}, m_addr, b.addr);
                    if (b.we) check({b.name, "_wd"}, m_wd, b.wd);
                end
                if (m_we) mem[m_addr[9:2]] = m_wd;
                else      m_rd = mem[m_addr[9:2]];
            end
            if (rd_vld) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_queue_empty: got 0x%08h required a queued value", s_rd);
                end else begin
                    r = rd_q.pop_front();
                    check(r.name, s_rd, r.val);
                end
            end
        end
    end

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        s_we = 1'b1; s_addr = a; s_wd = d;
        @(posedge clock); #1;
        s_we = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, input logic [31:0] exp, input string name);
        rd_t r;
        r.val = exp; r.name = name;
        rd_q.push_back(r);
        s_we = 1'b0; s_addr = a; rd_vld = 1'b1;
        @(negedge clock);
        @(posedge clock); #1;
        rd_vld = 1'b0;
    endtask

    task automatic expect_bus(input logic we, input logic [31:0] a, input logic [31:0] d, input string name);
        bus_t b;
        b.we = we; b.addr = a; b.wd = d; b.name = name;
        bus_q.push_back(b);
    endtask

    // Runs until busy drops; optionally removes grant for a window and checks the held outputs.
    task automatic wait_idle(input int stall_start, input int stall_len,
                             input logic [31:0] st_addr, input logic [31:0] st_wd,
                             output int n);
        n = 0;
        s_addr = 2'd3;
        m_gnt = 1'b1;
        do begin
            @(posedge clock); #1;
            n++;
            m_gnt = !(stall_len > 0 && n >= stall_start && n < stall_start + stall_len);
            if (stall_len > 0 && n >= stall_start && n <= stall_start + stall_len) begin
                check("stall_addr", m_addr, st_addr);
                check("stall_wd", m_wd, st_wd);
            end
        end while (s_rd[0] && n < 50);
        m_gnt = 1'b1;
        if (n >= 50) check("wait_idle_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        #12;
        check("reset_m_req", {31'b0, m_req}, 32'd0);
        check("reset_m_addr", m_addr, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        read_reg(2'd0, 32'h0, "reset_src");
        read_reg(2'd3, 32'h0, "reset_status");

        // Basic copy
        write_reg(2'd0, 32'h40);
        write_reg(2'd1, 32'h80);
        write_reg(2'd2, 32'd3);
        expect_bus(1'b0, 32'h40, 32'h0, "b_rd0");
        expect_bus(1'b1, 32'h80, 32'hA, "b_wr0");
        expect_bus(1'b0, 32'h44, 32'h0, "b_rd1");
        expect_bus(1'b1, 32'h84, 32'hB, "b_wr1");
        expect_bus(1'b0, 32'h48, 32'h0, "b_rd2");
        expect_bus(1'b1, 32'h88, 32'hC, "b_wr2");
        write_reg(2'd3, 32'h1);
        wait_idle(0, 0, 32'h0, 32'h0, n);
        check("basic_cycles", 32'(n), 32'd6);
        read_reg(2'd3, 32'h2, "basic_status");
        read_reg(2'd0, 32'h4C, "basic_src");
        read_reg(2'd1, 32'h8C, "basic_dst");
        read_reg(2'd2, 32'h0, "basic_len");
        check("basic_mem2", mem[8'h22], 32'hC);

        // Grant stall during the second write
        write_reg(2'd0, 32'h40);
        write_reg(2'd1, 32'hA0);
        write_reg(2'd2, 32'd3);
        expect_bus(1'b0, 32'h40, 32'h0, "s_rd0");
        expect_bus(1'b1, 32'hA0, 32'hA, "s_wr0");
        expect_bus(1'b0, 32'h44, 32'h0, "s_rd1");
        expect_bus(1'b1, 32'hA4, 32'hB, "s_wr1");
        expect_bus(1'b0, 32'h48, 32'h0, "s_rd2");
        expect_bus(1'b1, 32'hA8, 32'hC, "s_wr2");
        write_reg(2'd3, 32'h1);
        wait_idle(3, 3, 32'hA4, 32'hB, n);
        check("stall_cycles", 32'(n), 32'd9);
        check("stall_mem1", mem[8'h29], 32'hB);

        // DONE_CLR, then zero-length start
        write_reg(2'd3, 32'h2);
        read_reg(2'd3, 32'h0, "done_clr_status");
        write_reg(2'd2, 32'd0);
        write_reg(2'd3, 32'h1);
        check("zero_m_req", {31'b0, m_req}, 32'd0);
        read_reg(2'd3, 32'h2, "zero_status");

        // Writes to SRC while busy are ignored
        write_reg(2'd0, 32'h40);
        write_reg(2'd1, 32'hC0);
        write_reg(2'd2, 32'd2);
        expect_bus(1'b0, 32'h40, 32'h0, "z_rd0");
        expect_bus(1'b1, 32'hC0, 32'hA, "z_wr0");
        expect_bus(1'b0, 32'h44, 32'h0, "z_rd1");
        expect_bus(1'b1, 32'hC4, 32'hB, "z_wr1");
        write_reg(2'd3, 32'h1);
        write_reg(2'd0, 32'h100);
        wait_idle(0, 0, 32'h0, 32'h0, n);
        check("busy_cycles", 32'(n), 32'd3);
        read_reg(2'd0, 32'h48, "busy_src");
        check("busy_mem1", mem[8'h31], 32'hB);

        // Reset during the second read of a 4-word copy
        write_reg(2'd0, 32'h40);
        write_reg(2'd1, 32'h300);
        write_reg(2'd2, 32'd4);
        expect_bus(1'b0, 32'h40, 32'h0, "r_rd0");
        expect_bus(1'b1, 32'h300, 32'hA, "r_wr0");
        write_reg(2'd3, 32'h1);
        @(posedge clock);
        @(posedge clock); #1;
        m_gnt = 1'b0;
        check("rst_pre_m_req", {31'b0, m_req}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_m_req", {31'b0, m_req}, 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        read_reg(2'd0, 32'h0, "rst_src");
        read_reg(2'd1, 32'h0, "rst_dst");
        read_reg(2'd2, 32'h0, "rst_len");
        read_reg(2'd3, 32'h0, "rst_status");
        reset = 1'b0;
        m_gnt = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check("rst_after_m_req", {31'b0, m_req}, 32'd0);
        check("rst_mem0", mem[8'hC0], 32'hA);
        check("rst_mem1", mem[8'hC1], 32'h0);
        check("rst_queue", 32'(bus_q.size()), 32'd0);

        // Alignment and address wrap
        write_reg(2'd0, 32'hFFFF_FFFF);
        read_reg(2'd0, 32'hFFFF_FFFC, "align_src");
        write_reg(2'd1, 32'h200);
        write_reg(2'd2, 32'd2);
        expect_bus(1'b0, 32'hFFFF_FFFC, 32'h0, "w_rd0");
        expect_bus(1'b1, 32'h200, 32'h11, "w_wr0");
        expect_bus(1'b0, 32'h0000_0000, 32'h0, "w_rd1");
        expect_bus(1'b1, 32'h204, 32'h22, "w_wr1");
        write_reg(2'd3, 32'h1);
        wait_idle(0, 0, 32'h0, 32'h0, n);
        check("wrap_cycles", 32'(n), 32'd4);
        read_reg(2'd0, 32'h4, "wrap_src");
        read_reg(2'd1, 32'h208, "wrap_dst");
        check("wrap_mem1", mem[8'h81], 32'h22);

        // IE bit is absent in the default build
        write_reg(2'd3, 32'h6);
        read_reg(2'd3, 32'h0, "ie_absent_status");

        repeat (2) @(posedge clock);
        check("final_queue", 32'(bus_q.size() + rd_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dma_copy_engine.md
Name: dma_copy_engine

Overview:
- Memory-mapped word-copy DMA engine with two bus ports.
- Its register slave port is decoded by the SoC address decoder, like the other peripherals.
- Its master port issues reads and writes on the data-memory bus through a request/grant arbiter shared with the CPU.
- It copies LEN 32-bit words from SRC to DST without CPU involvement. CPU polls (or takes an interrupt on) completion.

Parameters:
- LEN_W, 12, width of the word-count register (max transfer 2^LEN_W-1 words)

Ports:
- clock  input  1  system clock
- reset  input  1  reset, asynchronous, active-high
- s_we  input  1  slave register write enable (from address decoder)
- s_addr  input  2  slave register select (bus address bits [3:2])
- s_wd  input  32  slave write data
- s_rd  output  32  slave read data (combinational)
- m_req  output  1  master bus request
- m_we  output  1  master write enable (valid while m_req)
- m_addr  output  32  master word address (valid while m_req)
- m_wd  output  32  master write data (valid while m_req & m_we)
- m_rd  input  32  master read data (valid combinationally in a granted read cycle)
- m_gnt  input  1  arbiter grant; access completes at the rising edge where m_req & m_gnt

Behaviour:
- Clock and reset: one clock; reset is asynchronous, active-high.
- Register map (s_addr):
  - 0 SRC: source address. On write, bits[1:0] are forced to 0.
  - 1 DST: destination address. On write, bits[1:0] are forced to 0.
  - 2 LEN: word count, LEN_W bits, zero-extended on read.
  - 3 CTRL/STATUS:
    - Write: bit0 START, bit1 DONE_CLR.
    - Read: {30'b0, done, busy}.
- SRC, DST and LEN read back live values: current addresses and remaining count.
- Register writes to 0..2 while busy are ignored. START while busy is ignored. DONE_CLR while busy is ignored.
- Reset: FSM goes to IDLE. SRC, DST, LEN, data buffer, done and busy are all 0. m_req, m_we, m_addr and m_wd are 0.
- A reset mid-transfer aborts immediately. No further bus requests are issued after reset asserts.
- FSM states:
  - IDLE: m_req=0.
    - START with LEN!=0: done<=0, busy<=1, go to RD.
    - START with LEN==0: done<=1, stay IDLE, no bus access.
    - START and DONE_CLR in the same write: START takes priority.
  - RD: m_req=1, m_we=0, m_addr=SRC.
    - On m_gnt: buffer<=m_rd, SRC<=SRC+4, go to WR.
  - WR: m_req=1, m_we=1, m_addr=DST, m_wd=buffer.
    - On m_gnt: DST<=DST+4, LEN<=LEN-1.
    - If LEN==1 before the decrement: busy<=0, done<=1, go to IDLE. Otherwise go to RD.
- Stall: while m_gnt=0, m_req, m_we, m_addr and m_wd hold stable. There is no timeout.
- Throughput: 2 granted cycles per word. The minimum transfer of N words takes 2N cycles from the first RD cycle.
- The first RD cycle is the cycle after the START write edge.
- Address arithmetic is modulo 2^32: 0xFFFFFFFC+4 wraps to 0x00000000.
- done is sticky until DONE_CLR or the next START.
- busy is 1 exactly while the FSM is in RD or WR.
- Overlapping SRC/DST regions are copied strictly ascending. No overlap correction.

Optional Feature:
- Macro: DMA_COPY_IRQ_EN.
- When defined:
  - Adds output irq (1 bit) and CTRL write bit2 IE, readable at STATUS bit2.
  - irq is a registered level = done & IE, reset 0.
  - irq deasserts the cycle after DONE_CLR, START or an IE=0 write.
- When undefined:
  - No irq port.
  - CTRL bit2 writes are ignored and read as 0.

Test Plan:
- Basic copy: SRC=0x40, DST=0x80, LEN=3, dmem[0x40..0x48]={0xA,0xB,0xC}, m_gnt=1, START -> 6 granted cycles alternating rd/wr; dmem[0x80..0x88]={0xA,0xB,0xC}; STATUS=0x2; SRC=0x4C, DST=0x8C, LEN=0.
- Grant stalls: same copy with m_gnt low for 3 cycles during the second WR -> m_addr=0x84, m_wd=0xB held stable throughout; completes in 9 cycles; data correct.
- Zero-length and busy: LEN=0, START -> done=1 next cycle, m_req never asserted. Then start LEN=2 and mid-transfer write SRC=0x100 -> SRC write is ignored and the copy completes from the original source.
- Reset mid-transfer: assert reset during the second RD of LEN=4 -> m_req=0 asynchronously; all registers read 0; no further writes to DST.
- Wrap and alignment: write SRC=0xFFFFFFFF -> reads back 0xFFFFFFFC. Then LEN=2 copy -> second read at 0x00000000.
- DMA_COPY_IRQ_EN: IE=1, LEN=1 copy -> irq rises one cycle after done. DONE_CLR -> irq falls next cycle. With the macro undefined, STATUS bit2 reads 0.
